// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a boot image over a byte stream, writes it into instruction memory
// and holds the core stalled until a complete image has been written.
// Stream format: one length byte (word count), then little-endian 32-bit words.

module imem_boot_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [31:0]       fetch_addr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              load_done,
    output logic              load_err,
    output logic              fetch_fault
);

    // Memory depth in words; also the largest legal length byte.
    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [8:0]  DEPTH_9B  = 9'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_lo;
    logic              taken;
    logic              len_ok;
    logic              last_word;

    assign taken     = rx_valid && rx_ready;
    assign len_ok    = (rx_data != 8'd0) && ({1'b0, rx_data} <= DEPTH_9B);
    assign last_word = ({1'b0, word_cnt} == (len - LEN_ONE));

    // Next-state decode; start only matters in IDLE, RUN and ERR.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LEN;
            ST_LEN:   if (taken) state_nxt = len_ok ? ST_DATA : ST_ERR;
            ST_DATA:  if (taken && (byte_cnt == 2'd3)) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_word ? ST_RUN : ST_DATA;
            ST_RUN:   if (start) state_nxt = ST_LEN;
            ST_ERR:   if (start) state_nxt = ST_LEN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            cpu_stall <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rx_ready  <= (state_nxt == ST_LEN) || (state_nxt == ST_DATA);
            mem_we    <= (state_nxt == ST_WRITE);
            cpu_stall <= (state_nxt != ST_RUN);
            load_done <= (state_nxt == ST_RUN);
            load_err  <= (state_nxt == ST_ERR);
        end
    end

    // Length capture, byte assembly and word counting. The 4th byte of a word
    // goes straight into the write-data register together with the address,
    // so both are stable for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            word_lo   <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_LEN: begin
                    if (taken && len_ok) begin
                        len      <= rx_data[ADDR_W:0];
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (taken) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= rx_data;
                            2'd1: word_lo[15:8]  <= rx_data;
                            2'd2: word_lo[23:16] <= rx_data;
                            default: begin
                                mem_wdata <= {rx_data, word_lo};
                                mem_waddr <= word_cnt;
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (!last_word) word_cnt <= word_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Fetch path: word index straight from the PC; fault only reported in RUN.
    always_comb begin
        mem_raddr   = fetch_addr[ADDR_W+1:2];
        fetch_fault = (state == ST_RUN) &&
                      ((fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0));
    end

endmodule
